// File: rtl/sum_ascii_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : sum_ascii_uart_tx
// Purpose  : Sends a 5-bit sum as a 4-byte ASCII record (two decimal digits,
//            CR, LF) over an 8N1 UART line with an internal baud divider.
// Revision : 1.0 - initial release
// ============================================================================
module sum_ascii_uart_tx #(
    parameter int CLKS_PER_BIT = 1042,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sum_valid,
    input  logic [4:0] sum_value,
    output logic       uart_txd,
    output logic       uart_tx_busy
);

    localparam logic [CNT_W-1:0] C_BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_cnt;
    logic [1:0]       r_byte_idx;
    logic [7:0]       r_shift;
    logic [1:0]       r_tens;
    logic [3:0]       r_ones;

    logic [1:0]       w_tens;
    logic [3:0]       w_ones;
    logic [7:0]       w_byte;
    logic             w_baud_wrap;

    // Decimal split by range compare; sum_value never exceeds 31.
    always_comb begin
        w_tens = 2'd0;
        w_ones = sum_value[3:0];
        if (sum_value >= 5'd30) begin
            w_tens = 2'd3;
            w_ones = 4'(sum_value - 5'd30);
        end else if (sum_value >= 5'd20) begin
            w_tens = 2'd2;
            w_ones = 4'(sum_value - 5'd20);
        end else if (sum_value >= 5'd10) begin
            w_tens = 2'd1;
            w_ones = 4'(sum_value - 5'd10);
        end
    end

    always_comb begin
        w_byte = 8'h0A;
        case (r_byte_idx)
            2'd0:    w_byte = 8'h30 + {6'd0, r_tens};
            2'd1:    w_byte = 8'h30 + {4'd0, r_ones};
            2'd2:    w_byte = 8'h0D;
            default: w_byte = 8'h0A;
        endcase
    end

    assign w_baud_wrap = (r_baud_cnt == C_BAUD_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_baud_cnt   <= '0;
            r_bit_cnt    <= 3'd0;
            r_byte_idx   <= 2'd0;
            r_shift      <= 8'd0;
            r_tens       <= 2'd0;
            r_ones       <= 4'd0;
            uart_txd     <= 1'b1;
            uart_tx_busy <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    uart_txd     <= 1'b1;
                    uart_tx_busy <= 1'b0;
                    if (sum_valid) begin
                        r_tens       <= w_tens;
                        r_ones       <= w_ones;
                        r_byte_idx   <= 2'd0;
                        r_bit_cnt    <= 3'd0;
                        r_baud_cnt   <= '0;
                        r_state      <= S_START;
                        uart_txd     <= 1'b0;
                        uart_tx_busy <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_baud_wrap) begin
                        r_baud_cnt <= '0;
                        r_shift    <= w_byte;
                        uart_txd   <= w_byte[0];
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_wrap) begin
                        r_baud_cnt <= '0;
                        if (r_bit_cnt == 3'd7) begin
                            r_bit_cnt <= 3'd0;
                            uart_txd  <= 1'b1;
                            r_state   <= S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            uart_txd  <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_baud_wrap) begin
                        r_baud_cnt <= '0;
                        if (r_byte_idx == 2'd3) begin
                            r_state      <= S_IDLE;
                            uart_txd     <= 1'b1;
                            uart_tx_busy <= 1'b0;
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_state    <= S_START;
                            uart_txd   <= 1'b0;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
